reservation_station_bank: RTL and testbench

RESERVATION_STATION_BANK -- requirements
Module: reservation_station_bank

---
 rtl/reservation_station_bank.sv | 197 +++++++++++++++++++
 tb/tb_reservation_station_bank.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station_bank.sv
// Reservation station bank: holds dispatched ops until their operands arrive on the CDB,
// then presents the oldest ready entry to the functional unit.
module reservation_station_bank #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned OP_W    = 10
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        flush,
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  logic [TAG_W-1:0]            disp_dest_tag,
    input  logic [NUM_SRC*TAG_W-1:0]    disp_src_tag,
    input  logic [NUM_SRC*DATA_W-1:0]   disp_src_val,
    input  logic [OP_W-1:0]             disp_op,
    input  logic                        cdb_valid,
    input  logic [TAG_W-1:0]            cdb_tag,
    input  logic [DATA_W-1:0]           cdb_val,
    output logic                        iss_valid,
    input  logic                        iss_ready,
    output logic [NUM_SRC*DATA_W-1:0]   iss_src_val,
    output logic [OP_W-1:0]             iss_op,
    output logic [TAG_W-1:0]            iss_dest_tag,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [NUM_SRC-1:0][TAG_W-1:0]  src_tag_t;
    typedef logic [NUM_SRC-1:0][DATA_W-1:0] src_val_t;

    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   dest_q  [DEPTH];
    logic [TAG_W-1:0]   dest_d  [DEPTH];
    logic [OP_W-1:0]    op_q    [DEPTH];
    logic [OP_W-1:0]    op_d    [DEPTH];
    src_tag_t           tag_q   [DEPTH];
    src_tag_t           tag_d   [DEPTH];
    src_val_t           val_q   [DEPTH];
    src_val_t           val_d   [DEPTH];
    logic [NUM_SRC-1:0] rdy_q   [DEPTH];
    logic [NUM_SRC-1:0] rdy_d   [DEPTH];
    // older_q[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0]   older_q [DEPTH];
    logic [DEPTH-1:0]   older_d [DEPTH];
    logic [CNT_W-1:0]   count_q, count_d;

    src_tag_t           disp_tag_c;
    src_val_t           disp_val_c;
    logic [DEPTH-1:0]   elig_c;
    logic [DEPTH-1:0]   oldest_c;
    logic               sel_found_c;
    logic [IDX_W-1:0]   sel_idx_c;
    logic               free_found_c;
    logic [IDX_W-1:0]   free_idx_c;
    logic               disp_fire_c;
    logic               iss_fire_c;

    assign disp_tag_c = disp_src_tag;
    assign disp_val_c = disp_src_val;

    // Oldest-eligible select over the age matrix
    always_comb begin
        elig_c      = '0;
        oldest_c    = '0;
        sel_found_c = 1'b0;
        sel_idx_c   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            elig_c[i] = valid_q[i] & (&rdy_q[i]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            oldest_c[i] = elig_c[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && elig_c[j] && older_q[j][i]) begin
                    oldest_c[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (oldest_c[i] && !sel_found_c) begin
                sel_found_c = 1'b1;
                sel_idx_c   = IDX_W'(i);
            end
        end
    end

    // Lowest-index free slot
    always_comb begin
        free_found_c = 1'b0;
        free_idx_c   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !free_found_c) begin
                free_found_c = 1'b1;
                free_idx_c   = IDX_W'(i);
            end
        end
    end

    assign disp_ready   = (count_q < CNT_W'(DEPTH));
    assign disp_fire_c  = disp_valid && disp_ready && free_found_c && !flush;
    assign iss_fire_c   = sel_found_c && iss_ready && !flush;

    assign iss_valid    = sel_found_c;
    assign iss_op       = sel_found_c ? op_q[sel_idx_c]   : '0;
    assign iss_dest_tag = sel_found_c ? dest_q[sel_idx_c] : '0;
    assign iss_src_val  = sel_found_c ? val_q[sel_idx_c]  : '0;
    assign count        = count_q;

    // Next-state: wakeup, issue-free, dispatch write, occupancy
    always_comb begin
        valid_d = valid_q;
        dest_d  = dest_q;
        op_d    = op_q;
        tag_d   = tag_q;
        val_d   = val_q;
        rdy_d   = rdy_q;
        older_d = older_q;
        count_d = count_q;

        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < NUM_SRC; j++) begin
                    if (valid_q[i] && !rdy_q[i][j] && cdb_valid &&
                        (cdb_tag != '0) && (tag_q[i][j] == cdb_tag)) begin
                        rdy_d[i][j] = 1'b1;
                        val_d[i][j] = cdb_val;
                    end
                end
            end

            if (iss_fire_c) begin
                valid_d[sel_idx_c] = 1'b0;
            end

            if (disp_fire_c) begin
                valid_d[free_idx_c] = 1'b1;
                dest_d[free_idx_c]  = disp_dest_tag;
                op_d[free_idx_c]    = disp_op;
                for (int j = 0; j < NUM_SRC; j++) begin
                    tag_d[free_idx_c][j] = disp_tag_c[j];
                    val_d[free_idx_c][j] = disp_val_c[j];
                    if (disp_tag_c[j] == '0) begin
                        rdy_d[free_idx_c][j] = 1'b1;
                    end else if (cdb_valid && (disp_tag_c[j] == cdb_tag)) begin
                        rdy_d[free_idx_c][j] = 1'b1;
                        val_d[free_idx_c][j] = cdb_val;
                    end else begin
                        rdy_d[free_idx_c][j] = 1'b0;
                    end
                end
                // New entry is younger than every entry already present
                for (int k = 0; k < DEPTH; k++) begin
                    older_d[k][free_idx_c] = 1'b1;
                end
                older_d[free_idx_c] = '0;
            end

            case ({disp_fire_c, iss_fire_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i]  <= '0;
                op_q[i]    <= '0;
                tag_q[i]   <= '0;
                val_q[i]   <= '0;
                rdy_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            dest_q  <= dest_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            val_q   <= val_d;
            rdy_q   <= rdy_d;
            older_q <= older_d;
        end
    end

endmodule

// File: tb/tb_reservation_station_bank.sv
// Directed bench for reservation_station_bank; issued entries are checked by a
// scoreboard monitor against expected records queued by the stimulus.
module tb_reservation_station_bank;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned NUM_SRC = 3;
    localparam int unsigned TAG_W   = 3;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OP_W    = 10;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned EXP_W   = TAG_W + OP_W + NUM_SRC * DATA_W;

    logic                       CLK;
    logic                       RST;
    logic                       flush;
    logic                       disp_valid;
    logic                       disp_ready;
    logic [TAG_W-1:0]           disp_dest_tag;
    logic [NUM_SRC*TAG_W-1:0]   disp_src_tag;
    logic [NUM_SRC*DATA_W-1:0]  disp_src_val;
    logic [OP_W-1:0]            disp_op;
    logic                       cdb_valid;
    logic [TAG_W-1:0]           cdb_tag;
    logic [DATA_W-1:0]          cdb_val;
    logic                       iss_valid;
    logic                       iss_ready;
    logic [NUM_SRC*DATA_W-1:0]  iss_src_val;
    logic [OP_W-1:0]            iss_op;
    logic [TAG_W-1:0]           iss_dest_tag;
    logic [CNT_W-1:0]           count;

    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_exp;
    int total;
    int bad;

    reservation_station_bank #(
        .DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)
    ) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_dest_tag(disp_dest_tag),
        .disp_src_tag(disp_src_tag), .disp_src_val(disp_src_val), .disp_op(disp_op),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_src_val(iss_src_val),
        .iss_op(iss_op), .iss_dest_tag(iss_dest_tag), .count(count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard monitor: every accepted issue must match the next expected record
    always @(negedge CLK) begin
        if (!RST && iss_valid === 1'b1 && iss_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL issue_unexpected: got dest=%0d op=0x%0h expected no issue",
                         iss_dest_tag, iss_op);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({iss_dest_tag, iss_op, iss_src_val} !== mon_exp) begin
                    bad++;
                    $display("FAIL issue_payload: got 0x%0h expected 0x%0h",
                             {iss_dest_tag, iss_op, iss_src_val}, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic disp(input logic [TAG_W-1:0] d, input logic [OP_W-1:0] o,
                        input logic [NUM_SRC*TAG_W-1:0] t, input logic [NUM_SRC*DATA_W-1:0] v);
        disp_valid    = 1'b1;
        disp_dest_tag = d;
        disp_op       = o;
        disp_src_tag  = t;
        disp_src_val  = v;
    endtask

    task automatic cdb(input logic v, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        cdb_valid = v;
        cdb_tag   = t;
        cdb_val   = d;
    endtask

    task automatic expect_issue(input logic [TAG_W-1:0] d, input logic [OP_W-1:0] o,
                                input logic [NUM_SRC*DATA_W-1:0] v);
        exp_q.push_back({d, o, v});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_dest_tag = '0;
        disp_src_tag = '0; disp_src_val = '0; disp_op = '0; iss_ready = 1'b0;
        cdb(1'b0, '0, '0);

        #12;
        check("rst_count", count, 0);
        check("rst_disp_ready", disp_ready, 1);
        check("rst_iss_valid", iss_valid, 0);
        check("rst_iss_fields", {iss_dest_tag, iss_op, iss_src_val}, 0);

        // Immediately ready op, dispatched on the first edge after reset release
        @(negedge CLK);
        RST = 1'b0;
        disp(3'd1, 10'h015, {3'd0, 3'd0, 3'd0}, {32'd9, 32'd7, 32'd5});
        iss_ready = 1'b1;
        expect_issue(3'd1, 10'h015, {32'd9, 32'd7, 32'd5});
        step();
        disp_valid = 1'b0;
        check("ready_count1", count, 1);
        check("ready_iss_valid", iss_valid, 1);
        check("ready_iss_val", iss_src_val, {32'd9, 32'd7, 32'd5});
        step();
        check("ready_count0", count, 0);
        check("ready_iss_idle", iss_valid, 0);

        // Operand 1 waits on tag 3, woken by a later broadcast
        disp(3'd2, 10'h036, {3'd0, 3'd3, 3'd0}, {32'h33, 32'hdead, 32'h11});
        expect_issue(3'd2, 10'h036, {32'h33, 32'hAA, 32'h11});
        step();
        disp_valid = 1'b0;
        check("wake_wait_iss", iss_valid, 0);
        check("wake_wait_count", count, 1);
        step();
        cdb(1'b1, 3'd3, 32'hAA);
        check("wake_no_bypass", iss_valid, 0);
        step();
        cdb(1'b0, '0, '0);
        check("wake_iss_valid", iss_valid, 1);
        check("wake_iss_val", iss_src_val, {32'h33, 32'hAA, 32'h11});
        step();
        check("wake_count0", count, 0);

        // Fill all entries with waiting ops, then try a fifth dispatch
        iss_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(TAG_W'(k + 1), OP_W'(k + 16), {3'd0, 3'd0, 3'd5}, {32'h22, 32'h11, 32'hdead});
            step();
        end
        disp_valid = 1'b0;
        check("full_count", count, 4);
        check("full_disp_ready", disp_ready, 0);
        check("full_iss_idle", iss_valid, 0);
        disp(3'd7, 10'h3ff, {3'd0, 3'd0, 3'd0}, {32'd1, 32'd2, 32'd3});
        step();
        disp_valid = 1'b0;
        check("full_reject_count", count, 4);
        cdb(1'b1, 3'd5, 32'h55);
        step();
        cdb(1'b0, '0, '0);
        check("full_oldest_dest", iss_dest_tag, 1);
        expect_issue(3'd1, 10'd16, {32'h22, 32'h11, 32'h55});
        iss_ready = 1'b1;
        check("full_ready_same_cycle", disp_ready, 0);
        step();
        iss_ready = 1'b0;
        check("free_disp_ready", disp_ready, 1);
        check("free_count", count, 3);
        check("free_next_dest", iss_dest_tag, 2);
        for (int k = 1; k < 4; k++) begin
            expect_issue(TAG_W'(k + 1), OP_W'(k + 16), {32'h22, 32'h11, 32'h55});
        end
        iss_ready = 1'b1;
        step();
        step();
        step();
        iss_ready = 1'b0;
        check("drain_count", count, 0);

        // Age ordering: older X overtakes younger Y once it becomes eligible
        disp(3'd5, 10'h055, {3'd0, 3'd0, 3'd2}, {32'h3, 32'h2, 32'h1});
        step();
        disp(3'd6, 10'h066, {3'd0, 3'd0, 3'd0}, {32'h6, 32'h5, 32'h4});
        step();
        disp_valid = 1'b0;
        check("age_y_first", iss_dest_tag, 6);
        cdb(1'b1, 3'd2, 32'h77);
        check("age_y_hold", iss_dest_tag, 6);
        step();
        cdb(1'b0, '0, '0);
        check("age_x_overtakes", iss_dest_tag, 5);
        expect_issue(3'd5, 10'h055, {32'h3, 32'h2, 32'h77});
        expect_issue(3'd6, 10'h066, {32'h6, 32'h5, 32'h4});
        iss_ready = 1'b1;
        step();
        check("age_y_after", iss_dest_tag, 6);
        step();
        iss_ready = 1'b0;
        check("age_count0", count, 0);

        // Dispatch bypass: tag matches the CDB in the same cycle
        iss_ready = 1'b1;
        disp(3'd3, 10'h0c4, {3'd4, 3'd0, 3'd0}, {32'hbad, 32'h8, 32'h7});
        cdb(1'b1, 3'd4, 32'hC4);
        expect_issue(3'd3, 10'h0c4, {32'hC4, 32'h8, 32'h7});
        step();
        disp_valid = 1'b0;
        cdb(1'b0, '0, '0);
        check("bypass_iss_valid", iss_valid, 1);
        check("bypass_iss_val", iss_src_val, {32'hC4, 32'h8, 32'h7});
        step();
        iss_ready = 1'b0;
        check("bypass_count0", count, 0);

        // Flush with a concurrent dispatch
        disp(3'd1, 10'h101, {3'd0, 3'd0, 3'd0}, {32'd1, 32'd1, 32'd1});
        step();
        disp(3'd2, 10'h102, {3'd0, 3'd0, 3'd6}, {32'd2, 32'd2, 32'd2});
        step();
        disp(3'd3, 10'h103, {3'd0, 3'd0, 3'd6}, {32'd3, 32'd3, 32'd3});
        step();
        check("pre_flush_count", count, 3);
        check("pre_flush_iss", iss_valid, 1);
        flush = 1'b1;
        disp(3'd4, 10'h104, {3'd0, 3'd0, 3'd0}, {32'd4, 32'd4, 32'd4});
        step();
        flush = 1'b0;
        disp_valid = 1'b0;
        check("flush_count", count, 0);
        check("flush_iss", iss_valid, 0);
        check("flush_disp_ready", disp_ready, 1);
        step();
        check("flush_drop_iss", iss_valid, 0);
        check("flush_drop_count", count, 0);

        // Asynchronous reset mid-stream
        disp(3'd1, 10'h201, {3'd0, 3'd0, 3'd0}, {32'd1, 32'd2, 32'd3});
        step();
        disp(3'd2, 10'h202, {3'd0, 3'd0, 3'd0}, {32'd4, 32'd5, 32'd6});
        step();
        disp_valid = 1'b0;
        check("mid_count", count, 2);
        check("mid_iss", iss_valid, 1);
        #2;
        RST = 1'b1;
        #1;
        check("async_count", count, 0);
        check("async_iss", iss_valid, 0);
        check("async_disp_ready", disp_ready, 1);
        check("async_fields", {iss_dest_tag, iss_op, iss_src_val}, 0);
        @(negedge CLK);
        RST = 1'b0;
        iss_ready = 1'b1;
        step();
        check("post_rst_iss", iss_valid, 0);
        check("post_rst_count", count, 0);
        iss_ready = 1'b0;
        step();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
